// File: rtl/can_msg_ctrl_if.sv
// Handshake and bus signals between user logic, the message controller and the CAN packet layer.
// slave = controller view; master = user/packet-layer environment view.
interface can_msg_ctrl_if #(
    parameter int DATA_BYTES = 4
);
    localparam int DW = 8 * DATA_BYTES;

    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic [3:0]    tx_len;
    logic          tx_ok;
    logic          tx_fail;
    logic [7:0]    tx_fail_cnt;

    logic          rx_valid;
    logic          rx_ready;
    logic [DW-1:0] rx_data;
    logic [3:0]    rx_len;
    logic [28:0]   rx_id;
    logic          rx_ide;
    logic [2:0]    rx_filt;
    logic [7:0]    rx_drop_cnt;

    logic          pkt_tx_start;
    logic [DW-1:0] pkt_tx_data;
    logic [3:0]    pkt_tx_len;
    logic          pkt_tx_done;
    logic          pkt_tx_acked;

    logic          pkt_rx_valid;
    logic [28:0]   pkt_rx_id;
    logic          pkt_rx_ide;
    logic          pkt_rx_rtr;
    logic [3:0]    pkt_rx_len;
    logic [63:0]   pkt_rx_data;
    logic          pkt_rx_ack;

    modport slave (
        input  tx_valid, tx_data, tx_len, rx_ready,
               pkt_tx_done, pkt_tx_acked,
               pkt_rx_valid, pkt_rx_id, pkt_rx_ide, pkt_rx_rtr, pkt_rx_len, pkt_rx_data,
        output tx_ready, tx_ok, tx_fail, tx_fail_cnt,
               rx_valid, rx_data, rx_len, rx_id, rx_ide, rx_filt, rx_drop_cnt,
               pkt_tx_start, pkt_tx_data, pkt_tx_len, pkt_rx_ack
    );

    modport master (
        output tx_valid, tx_data, tx_len, rx_ready,
               pkt_tx_done, pkt_tx_acked,
               pkt_rx_valid, pkt_rx_id, pkt_rx_ide, pkt_rx_rtr, pkt_rx_len, pkt_rx_data,
        input  tx_ready, tx_ok, tx_fail, tx_fail_cnt,
               rx_valid, rx_data, rx_len, rx_id, rx_ide, rx_filt, rx_drop_cnt,
               pkt_tx_start, pkt_tx_data, pkt_tx_len, pkt_rx_ack
    );
endinterface

// File: rtl/can_msg_ctrl.sv
// Purpose: CAN message controller - TX FIFO with retry, filter bank, RX FIFO between user and packet layer.
// Latency: TX launch 1 cycle after FIFO non-empty; RX ack/push 1 cycle after pkt_rx_valid.
// Backpressure: tx_ready = TX FIFO not full; RX uses valid/ready, frames arriving to a full FIFO are dropped and counted.
module can_msg_fifo #(
    parameter int W     = 8,
    parameter int ASIZE = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         wr_en,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << ASIZE;

    logic [W-1:0]   mem [DEPTH];
    logic [ASIZE:0] wr_ptr;
    logic [ASIZE:0] rd_ptr;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[ASIZE] != rd_ptr[ASIZE]) && (wr_ptr[ASIZE-1:0] == rd_ptr[ASIZE-1:0]);
    assign rd_dat = mem[rd_ptr[ASIZE-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en && !full) begin
                mem[wr_ptr[ASIZE-1:0]] <= wr_dat;
                wr_ptr                 <= wr_ptr + 1'b1;
            end
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

module can_msg_ctrl #(
    parameter int TX_ASIZE   = 2,
    parameter int RX_ASIZE   = 2,
    parameter int DATA_BYTES = 4,
    parameter int NUM_FILT   = 2,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [10:0]           cfg_local_id,
    input  logic [NUM_FILT-1:0]   cfg_filt_en,
    input  logic [NUM_FILT-1:0]   cfg_filt_ide,
    input  logic [29*NUM_FILT-1:0] cfg_filt_id,
    input  logic [29*NUM_FILT-1:0] cfg_filt_mask,
    can_msg_ctrl_if.slave         bus
);
    localparam int         DW     = 8 * DATA_BYTES;
    localparam logic [3:0] MAXLEN = 4'(DATA_BYTES);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    len;
    } tx_ent_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    len;
        logic [28:0]   id;
        logic          ide;
        logic [2:0]    filt;
    } rx_ent_t;

    typedef enum logic {IDLE, BUSY} state_t;

    // ---------------- TX path ----------------
    tx_ent_t tx_wr, tx_head;
    logic    tx_full, tx_empty, tx_pop;

    state_t        state;
    logic [3:0]    retry_cnt;
    logic          rtr_pend;
    logic          start_q;
    logic [DW-1:0] tx_data_q;
    logic [3:0]    tx_len_q;
    logic          tx_ok_q, tx_fail_q;
    logic [7:0]    fail_cnt_q;
    logic          rtr_hit;

    assign tx_wr.data = bus.tx_data;
    assign tx_wr.len  = (bus.tx_len == 4'd0 || bus.tx_len > MAXLEN) ? MAXLEN : bus.tx_len;
    assign tx_pop     = (state == IDLE) && !tx_empty;

    can_msg_fifo #(.W($bits(tx_ent_t)), .ASIZE(TX_ASIZE)) u_tx_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .wr_en  (bus.tx_valid),
        .wr_dat (tx_wr),
        .rd_en  (tx_pop),
        .rd_dat (tx_head),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            retry_cnt  <= '0;
            rtr_pend   <= 1'b0;
            start_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_len_q   <= MAXLEN;
            tx_ok_q    <= 1'b0;
            tx_fail_q  <= 1'b0;
            fail_cnt_q <= '0;
        end else begin
            tx_ok_q   <= 1'b0;
            tx_fail_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!tx_empty) begin
                        tx_data_q <= tx_head.data;
                        tx_len_q  <= tx_head.len;
                        retry_cnt <= '0;
                        start_q   <= 1'b1;
                        rtr_pend  <= 1'b0;
                        state     <= BUSY;
                    end else if (rtr_pend) begin
                        retry_cnt <= '0;
                        start_q   <= 1'b1;
                        rtr_pend  <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.pkt_tx_done) begin
                        if (bus.pkt_tx_acked) begin
                            tx_ok_q <= 1'b1;
                            start_q <= 1'b0;
                            state   <= IDLE;
                        end else if (retry_cnt == 4'(MAX_RETRY)) begin
                            tx_fail_q <= 1'b1;
                            if (fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'd1;
                            start_q <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            retry_cnt <= retry_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // A request arriving in the same cycle as a launch is kept for the next round.
            if (rtr_hit) rtr_pend <= 1'b1;
        end
    end

    assign bus.tx_ready     = !tx_full;
    assign bus.tx_ok        = tx_ok_q;
    assign bus.tx_fail      = tx_fail_q;
    assign bus.tx_fail_cnt  = fail_cnt_q;
    assign bus.pkt_tx_start = start_q;
    assign bus.pkt_tx_data  = tx_data_q;
    assign bus.pkt_tx_len   = tx_len_q;

    // ---------------- RX path ----------------
    logic [NUM_FILT-1:0] hit_vec;
    logic [2:0]          filt_idx;
    logic                filt_hit;
    logic                rx_full, rx_empty, rx_push, rx_drop;
    rx_ent_t             rx_wr, rx_head;
    logic                ack_q;
    logic [7:0]          drop_cnt_q;
    logic                unused_rx_bits;

    for (genvar g = 0; g < NUM_FILT; g++) begin : g_filt
        logic [28:0] diff;
        assign diff = (bus.pkt_rx_id ^ cfg_filt_id[29*g +: 29]) & cfg_filt_mask[29*g +: 29];
        assign hit_vec[g] = cfg_filt_en[g] && (cfg_filt_ide[g] == bus.pkt_rx_ide) &&
                            (bus.pkt_rx_ide ? (diff == '0) : (diff[10:0] == '0));
    end

    always_comb begin
        filt_idx = '0;
        for (int i = NUM_FILT - 1; i >= 0; i--) begin
            if (hit_vec[i]) filt_idx = 3'(i);
        end
    end

    assign filt_hit = |hit_vec;
    assign rtr_hit  = bus.pkt_rx_valid && bus.pkt_rx_rtr && !bus.pkt_rx_ide &&
                      (bus.pkt_rx_id[10:0] == cfg_local_id);
    assign rx_push  = bus.pkt_rx_valid && !bus.pkt_rx_rtr && filt_hit && !rx_full;
    assign rx_drop  = bus.pkt_rx_valid && !bus.pkt_rx_rtr && filt_hit && rx_full;

    assign rx_wr.data = bus.pkt_rx_data[63 -: DW];
    assign rx_wr.len  = bus.pkt_rx_len;
    assign rx_wr.id   = bus.pkt_rx_ide ? bus.pkt_rx_id : {18'd0, bus.pkt_rx_id[10:0]};
    assign rx_wr.ide  = bus.pkt_rx_ide;
    assign rx_wr.filt = filt_idx;
    assign unused_rx_bits = ^bus.pkt_rx_data;

    can_msg_fifo #(.W($bits(rx_ent_t)), .ASIZE(RX_ASIZE)) u_rx_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .wr_en  (rx_push),
        .wr_dat (rx_wr),
        .rd_en  (bus.rx_ready),
        .rd_dat (rx_head),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ack_q <= rtr_hit || rx_push;
            if (rx_drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign bus.pkt_rx_ack  = ack_q;
    assign bus.rx_drop_cnt = drop_cnt_q;
    assign bus.rx_valid    = !rx_empty;
    assign bus.rx_data     = rx_head.data;
    assign bus.rx_len      = rx_head.len;
    assign bus.rx_id       = rx_head.id;
    assign bus.rx_ide      = rx_head.ide;
    assign bus.rx_filt     = rx_head.filt;
endmodule
